// File: rtl/reg_scoreboard.sv
//==============================================================================
// Module      : reg_scoreboard
// Description : Issue-side register dependency tracker. Counts in-flight
//               writes per architectural register and stalls ID while a
//               source operand is still being produced. A per-register
//               counter prevents over-issue to one destination, and a total
//               counter bounds all outstanding writes.
//               Optional feature macro: SCOREBOARD_WB_BYPASS_EN. When it is
//               defined, a hazard on a register whose last pending write
//               retires in the same cycle is suppressed, because the
//               register-file write-through supplies that value.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2,
    parameter int TOT_W    = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             issue_valid_i,
    input  logic             issue_we_i,
    input  logic [4:0]       issue_rd_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic             use_rs1_i,
    input  logic             use_rs2_i,
    input  logic             wb_valid_i,
    input  logic [4:0]       wb_rd_i,
    output logic             stall_o,
    output logic             issue_fire_o,
    output logic [TOT_W-1:0] outstanding_o,
    output logic             empty_o,
    output logic             err_o
);

    // Register index width is fixed by the 5-bit port encoding.
    localparam int ADDR_W     = 5;
    localparam int ADDR_SPACE = 1 << ADDR_W;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [TOT_W-1:0] c_tot_max = '1;
    localparam logic [TOT_W-1:0] c_tot_one = TOT_W'(1);

    // Per-register counts across the whole 5-bit index space. Entries for x0
    // and for indices beyond NUM_REGS are tied to zero, so lookups never
    // need a range check.
    logic [CNT_W-1:0] w_cnt [ADDR_SPACE];

    logic [TOT_W-1:0] r_outstanding;
    logic             r_err;

    logic [CNT_W-1:0] w_rs1_cnt;
    logic [CNT_W-1:0] w_rs2_cnt;
    logic [CNT_W-1:0] w_rd_cnt;
    logic [CNT_W-1:0] w_wb_cnt;

    logic             w_byp1;
    logic             w_byp2;
    logic             w_hz1;
    logic             w_hz2;
    logic             w_full;
    logic             w_stall;
    logic             w_fire;

    logic             w_wb_nz;
    logic             w_inc;
    logic             w_dec;
    logic             w_orphan;

    assign w_rs1_cnt = w_cnt[rs1_i];
    assign w_rs2_cnt = w_cnt[rs2_i];
    assign w_rd_cnt  = w_cnt[issue_rd_i];
    assign w_wb_cnt  = w_cnt[wb_rd_i];

`ifdef SCOREBOARD_WB_BYPASS_EN
    // The last pending write of a source register retiring this cycle is
    // visible through the register-file write-through, so no hazard.
    assign w_byp1 = wb_valid_i && (wb_rd_i == rs1_i) && (w_rs1_cnt == c_cnt_one);
    assign w_byp2 = wb_valid_i && (wb_rd_i == rs2_i) && (w_rs2_cnt == c_cnt_one);
`else
    // Hazards follow the registered counts only.
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    assign w_hz1 = use_rs1_i && (rs1_i != '0) && (w_rs1_cnt != '0) && !w_byp1;
    assign w_hz2 = use_rs2_i && (rs2_i != '0) && (w_rs2_cnt != '0) && !w_byp2;

    // Refuse a new write when either its own counter or the total is at
    // its ceiling; this is what keeps the counters from ever wrapping.
    assign w_full = issue_we_i && (issue_rd_i != '0) &&
                    ((w_rd_cnt == c_cnt_max) || (r_outstanding == c_tot_max));

    assign w_stall = issue_valid_i && (w_hz1 || w_hz2 || w_full);
    assign w_fire  = issue_valid_i && !w_stall;

    // A retire to x0 is meaningless and is ignored entirely. A retire to a
    // register with nothing pending is an orphan and only flags an error.
    assign w_wb_nz  = wb_valid_i && (wb_rd_i != '0);
    assign w_inc    = w_fire && issue_we_i && (issue_rd_i != '0);
    assign w_dec    = w_wb_nz && (w_wb_cnt != '0);
    assign w_orphan = w_wb_nz && (w_wb_cnt == '0);

    generate
        for (genvar r = 0; r < ADDR_SPACE; r++) begin : g_reg
            if ((r == 0) || (r >= NUM_REGS)) begin : g_untracked
                assign w_cnt[r] = '0;
            end else begin : g_tracked
                localparam logic [ADDR_W-1:0] c_idx = ADDR_W'(r);

                logic [CNT_W-1:0] r_cnt;
                logic             w_inc_hit;
                logic             w_dec_hit;

                assign w_inc_hit = w_inc && (issue_rd_i == c_idx);
                assign w_dec_hit = w_dec && (wb_rd_i == c_idx);

                // In-flight write count for this register; an issue and a
                // retire hitting it in the same cycle cancel out.
                always_ff @(posedge clk_i) begin
                    if (!rst_n_i || flush_i) begin
                        r_cnt <= '0;
                    end else if (w_inc_hit && !w_dec_hit) begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end else if (w_dec_hit && !w_inc_hit) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end

                assign w_cnt[r] = r_cnt;
            end
        end
    endgenerate

    // Total in-flight writes, moved by the net change of this cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            r_outstanding <= '0;
        end else if (w_inc && !w_dec) begin
            r_outstanding <= r_outstanding + c_tot_one;
        end else if (w_dec && !w_inc) begin
            r_outstanding <= r_outstanding - c_tot_one;
        end
    end

    // Sticky orphan-retire flag; a flush discards that cycle's retire and
    // leaves the flag untouched.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_err <= 1'b0;
        end else if (!flush_i && w_orphan) begin
            r_err <= 1'b1;
        end
    end

    assign stall_o       = w_stall;
    assign issue_fire_o  = w_fire;
    assign outstanding_o = r_outstanding;
    assign empty_o       = (r_outstanding == '0);
    assign err_o         = r_err;

endmodule

`default_nettype wire

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Issue-side register dependency tracker for the pipelined RISC-V core. It is the producer-side counterpart to the EX-stage forwarding logic.
- Marks each destination register pending when a writing instruction issues from ID. Clears it when that write retires at WB.
- Raises a stall to ID while any source operand is still pending and its value cannot be supplied by a bypass path.
- Covers multi-cycle producers (loads, mul/div) whose results are not available in the MEM/WB forwarding window.

Parameters:
- NUM_REGS, 32, number of architectural integer registers; x0 is never tracked.
- CNT_W, 2, width of each per-register in-flight counter; at most 2^CNT_W-1 outstanding writes per register.
- TOT_W, 4, width of the total outstanding-write counter.

Ports:
- clk_i  in  1  core clock.
- rst_n_i  in  1  synchronous active-low reset.
- flush_i  in  1  pipeline flush; clears all pending state.
- issue_valid_i  in  1  ID presents an instruction this cycle.
- issue_we_i  in  1  the instruction writes rd.
- issue_rd_i  in  5  destination register.
- rs1_i  in  5  source register 1 of the ID instruction.
- rs2_i  in  5  source register 2 of the ID instruction.
- use_rs1_i  in  1  rs1 is actually read.
- use_rs2_i  in  1  rs2 is actually read.
- wb_valid_i  in  1  a register write retires this cycle.
- wb_rd_i  in  5  register being written at WB.
- stall_o  out  1  hold ID; the instruction is not issued.
- issue_fire_o  out  1  issue_valid_i && !stall_o.
- outstanding_o  out  TOT_W  total in-flight writes.
- empty_o  out  1  outstanding_o == 0.
- err_o  out  1  sticky: retire seen with no matching pending write.

Behaviour:
- Reset: when rst_n_i==0 at a clk_i edge, all counters, outstanding_o and err_o go to 0. empty_o=1, stall_o=0, issue_fire_o=0.
- State: cnt[r] holds CNT_W bits for r=1..NUM_REGS-1. cnt[0] is hard-wired to 0.
- Pending: pend(r) = cnt[r] != 0.
- stall_o (combinational) = issue_valid_i && (hz1 || hz2 || full), where:
  - hz1 = use_rs1_i && rs1_i != 0 && pend(rs1_i)
  - hz2 = use_rs2_i && rs2_i != 0 && pend(rs2_i)
  - full = issue_we_i && issue_rd_i != 0 && (cnt[issue_rd_i] == max || outstanding_o == max)
- Increment: on issue_fire_o && issue_we_i && issue_rd_i != 0, cnt[issue_rd_i] += 1 at the next edge and outstanding_o += 1.
- Decrement: on wb_valid_i && wb_rd_i != 0:
  - If cnt[wb_rd_i] != 0: cnt -= 1 and outstanding_o -= 1.
  - If cnt[wb_rd_i] == 0: counters are unchanged and err_o is set to 1. err_o clears only on reset.
- Simultaneous increment and decrement of the same register in one cycle: its count is unchanged and outstanding_o is unchanged. Different registers are updated independently. outstanding_o is updated by the net change (+1, 0 or −1).
- flush_i=1: all counters and outstanding_o are cleared at the next edge. Any issue or wb in that same cycle is ignored. err_o is kept.
- Latency: a write issued in cycle N makes pend() true from cycle N+1. A wb in cycle N clears the hazard from cycle N+1; with the optional feature below, the hazard clears in cycle N.
- Counters never wrap. Saturation is prevented by the full term, so increments never overflow.
- x0 never stalls and is never counted.

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined: a source hazard is suppressed in the same cycle when wb_valid_i && wb_rd_i == rs && cnt[rs] == 1, since the register-file write-through supplies the value. This saves one stall cycle per retire.
- Undefined: hazards depend only on registered cnt, giving one extra stall cycle after retire.

Test Plan:
1. Reset, then idle: stall_o=0, empty_o=1, outstanding_o=0, err_o=0.
2. Issue we rd=5; next cycle issue rs1=5 with use_rs1 → stall_o=1. wb rd=5:
   - Feature off: stall_o=0 one cycle later.
   - Feature on: stall_o=0 in the wb cycle.
   - outstanding_o goes 1→0.
3. Issue three writes to rd=7 with no wb → cnt[7]=3. A 4th issue to rd=7 → stall_o=1 and issue_fire_o=0. A wb to 7 releases the stall.
4. Same cycle: issue we rd=9 and wb rd=9 with cnt[9]=1 → cnt[9] stays 1 and outstanding_o is unchanged.
5. wb rd=12 with cnt[12]=0 → err_o=1 and stays 1. Counters unchanged.
6. Two writes pending (rd=3, rd=4), then assert flush_i → next cycle outstanding_o=0 and empty_o=1. Issue rs1=3 → no stall. Issue rd=0 with rs1=0 → no stall, no count.
